// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch state encoding and the
// opcode bit that marks two-byte instructions (also used by the CU decoder).
package cpu_pkg;

    localparam int            CPU_ADDR_W      = 8;
    localparam int            CPU_DATA_W      = 8;
    localparam int            CPU_OPERAND_BIT = 7;
    localparam logic [7:0]    CPU_RESET_PC    = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH_OP  = 2'd1,
        ST_FETCH_OPR = 2'd2,
        ST_HOLD      = 2'd3
    } fetch_state_e;

    function automatic logic is_fetch_state(fetch_state_e s);
        return (s == ST_FETCH_OP) || (s == ST_FETCH_OPR);
    endfunction

endpackage

// File: rtl/fu_pc.sv
// Program counter register: synchronous load has priority over increment,
// arithmetic wraps modulo 2^ADDR_W.
module fu_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              fu_clk,
    input  logic              fu_rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge fu_clk or negedge fu_rst_n) begin
        if (!fu_rst_n) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= load_val;
        end else if (inc) begin
            pc_q <= pc_q + ADDR_W'(1);
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode and optional operand byte from program
// RAM, holds them valid for the CU until acknowledged, and accepts PC loads.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W      = CPU_ADDR_W,
    parameter int                DATA_W      = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(CPU_RESET_PC),
    parameter int                OPERAND_BIT = CPU_OPERAND_BIT
) (
    input  logic              fu_clk,
    input  logic              fu_rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              stall,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    input  logic              cu_ack,
    output logic [DATA_W-1:0] ir_out,
    output logic [DATA_W-1:0] opr_out,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] pc_out
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc;
    logic              pc_ld;
    logic              pc_inc;
    logic              ir_we;
    logic              opr_we;
    logic              opr_clr;
    logic              take;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] opr_q;

    // A RAM completion only counts when a read is actually being requested.
    assign take  = is_fetch_state(state_q) && mem_ready && !stall;
    assign pc_ld = pc_load && (state_q != ST_IDLE);

    always_ff @(posedge fu_clk or negedge fu_rst_n) begin
        if (!fu_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_inc  = 1'b0;
        ir_we   = 1'b0;
        opr_we  = 1'b0;
        opr_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH_OP;
            end
            ST_FETCH_OP: begin
                if (take) begin
                    ir_we   = 1'b1;
                    opr_clr = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = mem_rdata[OPERAND_BIT] ? ST_FETCH_OPR : ST_HOLD;
                end
            end
            ST_FETCH_OPR: begin
                if (take) begin
                    opr_we  = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cu_ack) begin
                    state_d = ST_FETCH_OP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A jump flushes whatever this cycle would otherwise have committed.
        if (pc_ld) begin
            state_d = ST_FETCH_OP;
            pc_inc  = 1'b0;
            ir_we   = 1'b0;
            opr_we  = 1'b0;
            opr_clr = 1'b0;
        end
    end

    always_ff @(posedge fu_clk or negedge fu_rst_n) begin
        if (!fu_rst_n) begin
            ir_q  <= '0;
            opr_q <= '0;
        end else begin
            if (ir_we) begin
                ir_q <= mem_rdata;
            end
            if (opr_clr) begin
                opr_q <= '0;
            end else if (opr_we) begin
                opr_q <= mem_rdata;
            end
        end
    end

    fu_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .fu_clk   (fu_clk),
        .fu_rst_n (fu_rst_n),
        .load     (pc_ld),
        .load_val (pc_load_val),
        .inc      (pc_inc),
        .pc       (pc)
    );

    assign mem_addr = pc;
    assign pc_out   = pc;
    assign mem_rd   = is_fetch_state(state_q) && !stall;
    assign ir_valid = (state_q == ST_HOLD);
    assign ir_out   = ir_q;
    assign opr_out  = opr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table against a byte-array
// RAM model, plus a hand-written asynchronous reset during operand fetch.
module tb_fetch_unit;

    logic       fu_clk;
    logic       fu_rst_n;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic       stall;
    logic       pc_load;
    logic [7:0] pc_load_val;
    logic       cu_ack;
    logic [7:0] ir_out;
    logic [7:0] opr_out;
    logic       ir_valid;
    logic [7:0] pc_out;

    logic [7:0] ram [256];

    int checks;
    int errors;

    typedef struct {
        logic       stall;
        logic       ready;
        logic       ld;
        logic [7:0] ld_val;
        logic       ack;
        logic       exp_rd;
        logic       exp_valid;
        logic [7:0] exp_ir;
        logic [7:0] exp_opr;
        logic [7:0] exp_pc;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    fetch_unit dut (
        .fu_clk      (fu_clk),
        .fu_rst_n    (fu_rst_n),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .stall       (stall),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .cu_ack      (cu_ack),
        .ir_out      (ir_out),
        .opr_out     (opr_out),
        .ir_valid    (ir_valid),
        .pc_out      (pc_out)
    );

    // Zero-wait RAM: data always presented for the current address.
    assign mem_rdata = ram[mem_addr];

    initial fu_clk = 1'b0;
    always #5 fu_clk = ~fu_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int i, input logic s, input logic r, input logic l,
                           input logic [7:0] lv, input logic a, input logic e_rd,
                           input logic e_v, input logic [7:0] e_ir,
                           input logic [7:0] e_opr, input logic [7:0] e_pc);
        vecs[i] = '{s, r, l, lv, a, e_rd, e_v, e_ir, e_opr, e_pc};
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 256; a++) ram[a] = 8'h00;
        ram[8'h00] = 8'h12;
        ram[8'h01] = 8'h85;
        ram[8'h02] = 8'h3C;
        ram[8'h03] = 8'h21;
        ram[8'h04] = 8'h55;
        ram[8'h10] = 8'h8A;
        ram[8'h11] = 8'h66;
        ram[8'h20] = 8'hC3;
        ram[8'h40] = 8'h07;
        ram[8'hFF] = 8'h90;

        // Inputs applied during a cycle; outputs expected during that same cycle.
        //          stall rdy ld ldval ack | rd  vld  ir     opr    pc
        set_vec( 0, 0, 1, 0, 8'h00, 0,  0, 0, 8'h00, 8'h00, 8'h00); // IDLE
        set_vec( 1, 0, 1, 0, 8'h00, 0,  1, 0, 8'h00, 8'h00, 8'h00); // opcode @0
        set_vec( 2, 0, 1, 0, 8'h00, 0,  0, 1, 8'h12, 8'h00, 8'h01); // hold
        set_vec( 3, 0, 1, 0, 8'h00, 1,  0, 1, 8'h12, 8'h00, 8'h01); // ack
        set_vec( 4, 0, 1, 0, 8'h00, 0,  1, 0, 8'h12, 8'h00, 8'h01); // opcode @1
        set_vec( 5, 0, 1, 0, 8'h00, 0,  1, 0, 8'h85, 8'h00, 8'h02); // operand @2
        set_vec( 6, 0, 1, 0, 8'h00, 1,  0, 1, 8'h85, 8'h3C, 8'h03); // hold + ack
        set_vec( 7, 0, 0, 0, 8'h00, 0,  1, 0, 8'h85, 8'h3C, 8'h03); // waiting
        set_vec( 8, 1, 0, 0, 8'h00, 0,  0, 0, 8'h85, 8'h3C, 8'h03); // stall
        set_vec( 9, 1, 1, 0, 8'h00, 0,  0, 0, 8'h85, 8'h3C, 8'h03); // ready under stall
        set_vec(10, 0, 1, 0, 8'h00, 0,  1, 0, 8'h85, 8'h3C, 8'h03); // accept 0x21
        set_vec(11, 1, 1, 0, 8'h00, 1,  0, 1, 8'h21, 8'h00, 8'h04); // stall in hold
        set_vec(12, 0, 1, 1, 8'h40, 0,  1, 0, 8'h21, 8'h00, 8'h04); // load vs ready
        set_vec(13, 0, 0, 0, 8'h00, 0,  1, 0, 8'h21, 8'h00, 8'h40);
        set_vec(14, 0, 1, 0, 8'h00, 0,  1, 0, 8'h21, 8'h00, 8'h40); // RAM[40]
        set_vec(15, 0, 1, 1, 8'hFF, 0,  0, 1, 8'h07, 8'h00, 8'h41); // load from hold
        set_vec(16, 0, 1, 0, 8'h00, 0,  1, 0, 8'h07, 8'h00, 8'hFF); // opcode @FF
        set_vec(17, 1, 1, 0, 8'h00, 0,  0, 0, 8'h90, 8'h00, 8'h00); // wrapped, stalled
        set_vec(18, 0, 1, 0, 8'h00, 0,  1, 0, 8'h90, 8'h00, 8'h00); // operand @00
        set_vec(19, 0, 1, 1, 8'h10, 1,  0, 1, 8'h90, 8'h12, 8'h01); // load + ack
        set_vec(20, 0, 1, 0, 8'h00, 0,  1, 0, 8'h90, 8'h12, 8'h10); // opcode @10
        set_vec(21, 0, 1, 1, 8'h20, 0,  1, 0, 8'h8A, 8'h00, 8'h11); // load in OPR
        set_vec(22, 0, 0, 0, 8'h00, 0,  1, 0, 8'h8A, 8'h00, 8'h20);
        set_vec(23, 0, 1, 0, 8'h00, 0,  1, 0, 8'h8A, 8'h00, 8'h20); // opcode @20
        set_vec(24, 0, 0, 0, 8'h00, 0,  1, 0, 8'hC3, 8'h00, 8'h21); // in FETCH_OPR

        fu_rst_n    = 1'b0;
        stall       = 1'b0;
        mem_ready   = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = 8'h00;
        cu_ack      = 1'b0;

        @(negedge fu_clk);
        #1;
        check("rst_mem_rd",   {31'd0, mem_rd},   32'd0);
        check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("rst_pc",       {24'd0, pc_out},   32'd0);
        check("rst_ir",       {24'd0, ir_out},   32'd0);
        check("rst_opr",      {24'd0, opr_out},  32'd0);

        @(negedge fu_clk);
        fu_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            stall       = vecs[i].stall;
            mem_ready   = vecs[i].ready;
            pc_load     = vecs[i].ld;
            pc_load_val = vecs[i].ld_val;
            cu_ack      = vecs[i].ack;
            #1;
            check($sformatf("v%0d_mem_rd", i),   {31'd0, mem_rd},   {31'd0, vecs[i].exp_rd});
            check($sformatf("v%0d_ir_valid", i), {31'd0, ir_valid}, {31'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_ir_out", i),   {24'd0, ir_out},   {24'd0, vecs[i].exp_ir});
            check($sformatf("v%0d_opr_out", i),  {24'd0, opr_out},  {24'd0, vecs[i].exp_opr});
            check($sformatf("v%0d_pc_out", i),   {24'd0, pc_out},   {24'd0, vecs[i].exp_pc});
            check($sformatf("v%0d_mem_addr", i), {24'd0, mem_addr}, {24'd0, vecs[i].exp_pc});
            if (i < NVEC - 1) @(negedge fu_clk);
        end

        // Asynchronous reset while waiting on the operand byte: no clock edge.
        #2;
        fu_rst_n = 1'b0;
        #1;
        check("arst_pc",       {24'd0, pc_out},   32'd0);
        check("arst_ir_valid", {31'd0, ir_valid}, 32'd0);
        check("arst_mem_rd",   {31'd0, mem_rd},   32'd0);
        check("arst_ir",       {24'd0, ir_out},   32'd0);
        check("arst_opr",      {24'd0, opr_out},  32'd0);

        // Ready stays high through release: IDLE must not read, then restart at 0.
        mem_ready = 1'b1;
        @(negedge fu_clk);
        fu_rst_n = 1'b1;
        #1;
        check("rel_idle_mem_rd", {31'd0, mem_rd}, 32'd0);
        @(negedge fu_clk);
        #1;
        check("rel_fetch_mem_rd",   {31'd0, mem_rd},   32'd1);
        check("rel_fetch_mem_addr", {24'd0, mem_addr}, 32'd0);

        begin : wait_valid
            int budget;
            budget = 0;
            while (ir_valid !== 1'b1 && budget < 10) begin
                @(negedge fu_clk);
                #1;
                budget++;
            end
            check("rel_valid_timeout", {31'd0, ir_valid}, 32'd1);
            check("rel_ir",            {24'd0, ir_out},   32'h12);
            check("rel_pc",            {24'd0, pc_out},   32'h01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
